// File: rtl/pc_mem_arbiter_pkg.sv
// Shared definitions for the PC / shared-memory-port arbiter.
//   MEM_OP_*         EX-stage memory request encodings (2'b11 is reserved and means no access)
//   S_RST/S_FETCH/S_DATA  arbiter FSM state encodings
//   RESET_PC_DEFAULT default first fetch address after reset
//   is_mem_access()  true for a request that must take the port (load or store)
package pc_mem_arbiter_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [1:0] S_RST   = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_DATA  = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_mem_access(input logic [1:0] op);
        case (op)
            MEM_OP_LOAD, MEM_OP_STORE: return 1'b1;
            MEM_OP_NONE:               return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_mem_arbiter_redirect.sv
// pc_redirect_latch: holds one pending fetch redirect that arrived while the
// memory port could not accept it.
//   clk, rst          clock, synchronous active-low reset
//   clear             drop the pending redirect (it has just been consumed)
//   set_flush         record flush_target; always overrides a pending branch
//   set_branch        record branch_target unless a flush is already pending
//   pend, pend_v      pending target and its valid flag
module pc_redirect_latch
    import pc_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              set_flush,
    input  logic [ADDR_W-1:0] flush_target,
    input  logic              set_branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pend,
    output logic              pend_v
);

    // Remembers whether the pending target came from a flush, so a later
    // branch cannot overwrite it.
    logic pend_is_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend          <= '0;
            pend_v        <= 1'b0;
            pend_is_flush <= 1'b0;
        end else if (clear) begin
            pend_v        <= 1'b0;
            pend_is_flush <= 1'b0;
        end else if (set_flush) begin
            pend          <= flush_target;
            pend_v        <= 1'b1;
            pend_is_flush <= 1'b1;
        end else if (set_branch && !(pend_v && pend_is_flush)) begin
            pend          <= branch_target;
            pend_v        <= 1'b1;
            pend_is_flush <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_mem_arbiter.sv
// pc_mem_arbiter: fetch PC generator and arbiter for a memory port shared by
// instruction fetch and EX-stage loads/stores. Accesses may take several
// cycles (mem_ready_i); redirects arriving meanwhile are kept pending.
// Optional macro PC_MISALIGN_EN: misaligned redirect targets raise
// excp_misalign_o instead of being silently aligned.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   flush, new_pc            pipeline flush and its target
//   stall_i                  PC stage stall
//   branch_flag_i/_target_i  taken branch from ID
//   mem_op_i, mem_addr_i, mem_wdata_i, mem_be_i  EX load/store request
//   mem_ready_i              current access completes this cycle
//   mem_ce/we/addr/wdata/be_o  memory port (registered)
//   pc_o                     PC of the instruction owning the current access
//   inst_valid_o             current access is a fetch
//   data_access_o            current access is a load/store
//   busy_o                   stall request: access pending and not ready
//   excp_misalign_o          (PC_MISALIGN_EN only) misaligned fetch target pulse
module pc_mem_arbiter
    import pc_mem_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       BE_W       = DATA_W / 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [1:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [BE_W-1:0]   mem_be_i,
    input  logic              mem_ready_i,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    output logic              data_access_o,
    output logic              busy_o
`ifdef PC_MISALIGN_EN
    ,
    output logic              excp_misalign_o
`endif
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] last_pc;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] flush_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] pend;
    logic              pend_v;
    logic              complete;
    logic              latch_branch;

    logic              do_fetch;
    logic              do_data;
    logic [ADDR_W-1:0] fetch_addr;
    logic              pl_clear;
    logic              pl_set_flush;
    logic              pl_set_branch;

    assign complete     = mem_ce_o & mem_ready_i;
    assign busy_o       = mem_ce_o & ~mem_ready_i;
    assign seq_pc       = last_pc + ADDR_W'(INST_BYTES);
    assign latch_branch = branch_flag_i & ~stall_i;

`ifdef PC_MISALIGN_EN
    logic fetch_misaligned;
    assign flush_tgt        = new_pc;
    assign br_tgt           = branch_target_i;
    assign fetch_misaligned = |(fetch_addr & LOW_MASK);
`else
    assign flush_tgt = new_pc & ~LOW_MASK;
    assign br_tgt    = branch_target_i & ~LOW_MASK;
`endif

    pc_redirect_latch #(
        .ADDR_W(ADDR_W)
    ) u_redirect (
        .clk          (clk),
        .rst          (rst),
        .clear        (pl_clear),
        .set_flush    (pl_set_flush),
        .flush_target (flush_tgt),
        .set_branch   (pl_set_branch),
        .branch_target(br_tgt),
        .pend         (pend),
        .pend_v       (pend_v)
    );

    // Next-access selection. A non-completing edge only records redirects.
    always_comb begin
        do_fetch      = 1'b0;
        do_data       = 1'b0;
        fetch_addr    = last_pc;
        pl_clear      = 1'b0;
        pl_set_flush  = 1'b0;
        pl_set_branch = 1'b0;
        case (state)
            S_RST: begin
                do_fetch      = 1'b1;
                fetch_addr    = RESET_PC;
                pl_set_flush  = flush;
                pl_set_branch = latch_branch;
            end
            S_FETCH: begin
                if (!mem_ce_o) begin
                    // Parked after a misaligned target: only a flush leaves.
                    if (flush) begin
                        do_fetch   = 1'b1;
                        fetch_addr = flush_tgt;
                        pl_clear   = 1'b1;
                    end
                end else if (complete) begin
                    if (flush) begin
                        do_fetch   = 1'b1;
                        fetch_addr = flush_tgt;
                        pl_clear   = 1'b1;
                    end else if (is_mem_access(mem_op_i)) begin
                        // Data steals the port; a coincident branch waits.
                        do_data       = 1'b1;
                        pl_set_branch = latch_branch;
                    end else begin
                        do_fetch = 1'b1;
                        pl_clear = 1'b1;
                        if (pend_v)             fetch_addr = pend;
                        else if (stall_i)       fetch_addr = last_pc;
                        else if (branch_flag_i) fetch_addr = br_tgt;
                        else                    fetch_addr = seq_pc;
                    end
                end else begin
                    pl_set_flush  = flush;
                    pl_set_branch = latch_branch;
                end
            end
            S_DATA: begin
                if (complete) begin
                    do_fetch = 1'b1;
                    pl_clear = 1'b1;
                    if (flush)        fetch_addr = flush_tgt;
                    else if (pend_v)  fetch_addr = pend;
                    else if (stall_i) fetch_addr = last_pc;
                    else              fetch_addr = seq_pc;
                end else begin
                    pl_set_flush  = flush;
                    pl_set_branch = latch_branch;
                end
            end
            default: begin
                do_fetch   = 1'b1;
                fetch_addr = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_RST;
            mem_ce_o      <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= RESET_PC;
            mem_wdata_o   <= '0;
            mem_be_o      <= '0;
            pc_o          <= RESET_PC;
            inst_valid_o  <= 1'b0;
            data_access_o <= 1'b0;
            last_pc       <= RESET_PC;
`ifdef PC_MISALIGN_EN
            excp_misalign_o <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_EN
            excp_misalign_o <= 1'b0;
`endif
            if (do_data) begin
                state         <= S_DATA;
                mem_ce_o      <= 1'b1;
                mem_we_o      <= (mem_op_i == MEM_OP_STORE);
                mem_addr_o    <= mem_addr_i;
                mem_wdata_o   <= mem_wdata_i;
                mem_be_o      <= mem_be_i;
                pc_o          <= last_pc;
                inst_valid_o  <= 1'b0;
                data_access_o <= 1'b1;
            end else if (do_fetch) begin
                state <= S_FETCH;
                pc_o  <= fetch_addr;
`ifdef PC_MISALIGN_EN
                if (fetch_misaligned) begin
                    mem_ce_o        <= 1'b0;
                    mem_we_o        <= 1'b0;
                    inst_valid_o    <= 1'b0;
                    data_access_o   <= 1'b0;
                    excp_misalign_o <= 1'b1;
                end else
`endif
                begin
                    mem_ce_o      <= 1'b1;
                    mem_we_o      <= 1'b0;
                    mem_addr_o    <= fetch_addr;
                    mem_be_o      <= '1;
                    inst_valid_o  <= 1'b1;
                    data_access_o <= 1'b0;
                    last_pc       <= fetch_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_mem_arbiter.sv
// Self-checking bench for pc_mem_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_pc_mem_arbiter;
    import pc_mem_arbiter_pkg::*;

    localparam int unsigned IB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [1:0]  mem_op_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_be_i = '0;
    logic        mem_ready_i = 1'b1;

    logic        mem_ce_o, mem_we_o, inst_valid_o, data_access_o, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, pc_o;
    logic [3:0]  mem_be_o;
`ifdef PC_MISALIGN_EN
    logic        excp_misalign_o;
`endif

    pc_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .BE_W      (4),
        .RESET_PC  (32'h0000_0000),
        .INST_BYTES(IB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .mem_op_i       (mem_op_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_be_i       (mem_be_i),
        .mem_ready_i    (mem_ready_i),
        .mem_ce_o       (mem_ce_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .pc_o           (pc_o),
        .inst_valid_o   (inst_valid_o),
        .data_access_o  (data_access_o),
        .busy_o         (busy_o)
`ifdef PC_MISALIGN_EN
        ,
        .excp_misalign_o(excp_misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; new_pc = '0; stall_i = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = '0; mem_op_i = 2'b00; mem_addr_i = '0;
        mem_wdata_i = '0; mem_be_i = '0; mem_ready_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fl;
        logic [31:0] npc;
        logic        st;
        logic        br;
        logic [31:0] tg;
        logic [1:0]  op;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rdy;
        logic        e_ce;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [3:0]  e_be;
        logic        e_iv;
        logic        e_da;
        logic        e_busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic fl, input logic [31:0] npc, input logic st,
                               input logic br, input logic [31:0] tg, input logic [1:0] op,
                               input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] be,
                               input logic rdy, input logic e_ce, input logic e_we,
                               input logic [31:0] e_addr, input logic [31:0] e_pc,
                               input logic [3:0] e_be, input logic e_iv, input logic e_da,
                               input logic e_busy);
        vec_t r;
        r.fl = fl; r.npc = npc; r.st = st; r.br = br; r.tg = tg; r.op = op;
        r.ma = ma; r.wd = wd; r.be = be; r.rdy = rdy;
        r.e_ce = e_ce; r.e_we = e_we; r.e_addr = e_addr; r.e_pc = e_pc;
        r.e_be = e_be; r.e_iv = e_iv; r.e_da = e_da; r.e_busy = e_busy;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Model state is the current access itself plus a queue holding at most
    // one pending redirect.
    int          m_kind;          // 0 = after reset, 1 = fetch slot, 2 = data slot
    logic        m_ce, m_we, m_iv, m_da, m_exc;
    logic [31:0] m_addr, m_pc, m_last, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] pendq[$];
    bit          pend_from_flush;

    function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef PC_MISALIGN_EN
        return a;
`else
        return a - (a % IB);
`endif
    endfunction

    task automatic m_issue(input logic [31:0] a);
        m_kind = 1;
        m_pc   = a;
`ifdef PC_MISALIGN_EN
        if (a % IB != 0) begin
            m_ce = 0; m_we = 0; m_iv = 0; m_da = 0; m_exc = 1;
            return;
        end
`endif
        m_ce = 1; m_we = 0; m_addr = a; m_be = 4'hF; m_iv = 1; m_da = 0; m_last = a;
    endtask

    task automatic m_note_redirects();
        if (flush) begin
            pendq.delete();
            pendq.push_back(fix(new_pc));
            pend_from_flush = 1;
        end else if (branch_flag_i && !stall_i && !(pendq.size() != 0 && pend_from_flush)) begin
            pendq.delete();
            pendq.push_back(fix(branch_target_i));
            pend_from_flush = 0;
        end
    endtask

    task automatic m_step();
        logic        done;
        logic [31:0] a;
        if (!rst) begin
            m_kind = 0; m_ce = 0; m_we = 0; m_addr = 0; m_pc = 0; m_wdata = 0;
            m_be = 0; m_iv = 0; m_da = 0; m_last = 0; m_exc = 0;
            pendq.delete();
            return;
        end
        m_exc = 0;
        done  = m_ce && mem_ready_i;
        if (m_kind == 0) begin
            m_note_redirects();
            m_issue(32'h0);
        end else if (m_kind == 1) begin
            if (!m_ce) begin
                if (flush) begin
                    pendq.delete();
                    m_issue(fix(new_pc));
                end
            end else if (done) begin
                if (flush) begin
                    pendq.delete();
                    m_issue(fix(new_pc));
                end else if (mem_op_i == 2'b01 || mem_op_i == 2'b10) begin
                    m_kind = 2; m_ce = 1; m_we = (mem_op_i == 2'b10);
                    m_addr = mem_addr_i; m_wdata = mem_wdata_i; m_be = mem_be_i;
                    m_pc = m_last; m_iv = 0; m_da = 1;
                    m_note_redirects();
                end else if (pendq.size() != 0) begin
                    a = pendq.pop_front();
                    m_issue(a);
                end else if (stall_i) begin
                    m_issue(m_last);
                end else if (branch_flag_i) begin
                    m_issue(fix(branch_target_i));
                end else begin
                    m_issue(m_last + IB);
                end
            end else begin
                m_note_redirects();
            end
        end else begin
            if (done) begin
                if (flush)                 a = fix(new_pc);
                else if (pendq.size() != 0) a = pendq[0];
                else if (stall_i)          a = m_last;
                else                       a = m_last + IB;
                pendq.delete();
                m_issue(a);
            end else begin
                m_note_redirects();
            end
        end
    endtask

    initial begin
        // ---- reset ----
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", 32'(mem_ce_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_be", 32'(mem_be_o), 32'h0);
        chk("rst_iv", 32'(inst_valid_o), 32'd0);
        chk("rst_da", 32'(data_access_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b1;

        // ---- directed table ----
        //        fl npc     st br tg      op ma      wd            be   rdy ce we addr    pc      be   iv da busy
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h0,  32'h0,  4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h4,  32'h4,  4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h8,  32'h8,  4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     1, 32'h100, 0,          4'hF,1,  1, 0, 32'h100,32'h8,  4'hF, 0, 1, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'hC,  32'hC,  4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     2, 32'h200, 32'hDEADBEEF, 4'hF,1,1, 1, 32'h200,32'hC,  4'hF, 0, 1, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   0,  1, 1, 32'h200,32'hC,  4'hF, 0, 1, 1));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   0,  1, 1, 32'h200,32'hC,  4'hF, 0, 1, 1));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   0,  1, 1, 32'h200,32'hC,  4'hF, 0, 1, 1));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h10, 32'h10, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 1, 32'h40,1, 32'h300, 0,          4'hF,1,  1, 0, 32'h300,32'h10, 4'hF, 0, 1, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h40, 32'h40, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h44, 32'h44, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 1, 32'h40,2, 32'h204, 32'h12345678, 4'h3,1,1, 1, 32'h204,32'h44, 4'h3, 0, 1, 0));
        vt.push_back(v(1, 32'h80,0, 0, 0,     0, 0,     0,            0,   0,  1, 1, 32'h204,32'h44, 4'h3, 0, 1, 1));
        vt.push_back(v(0, 0,     0, 1, 32'h60,0, 0,     0,            0,   0,  1, 1, 32'h204,32'h44, 4'h3, 0, 1, 1));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h80, 32'h80, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h84, 32'h84, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     1, 0, 0,     0, 0,     0,            0,   1,  1, 0, 32'h84, 32'h84, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 1, 32'h48,0, 0,     0,            0,   1,  1, 0, 32'h48, 32'h48, 4'hF, 1, 0, 0));
        vt.push_back(v(0, 0,     0, 0, 0,     3, 32'h700, 0,          4'hF,1,  1, 0, 32'h4C, 32'h4C, 4'hF, 1, 0, 0));

        foreach (vt[i]) begin
            flush = vt[i].fl; new_pc = vt[i].npc; stall_i = vt[i].st;
            branch_flag_i = vt[i].br; branch_target_i = vt[i].tg; mem_op_i = vt[i].op;
            mem_addr_i = vt[i].ma; mem_wdata_i = vt[i].wd; mem_be_i = vt[i].be;
            mem_ready_i = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_ce", i), 32'(mem_ce_o), 32'(vt[i].e_ce));
            chk($sformatf("vec%0d_we", i), 32'(mem_we_o), 32'(vt[i].e_we));
            chk($sformatf("vec%0d_addr", i), mem_addr_o, vt[i].e_addr);
            chk($sformatf("vec%0d_pc", i), pc_o, vt[i].e_pc);
            chk($sformatf("vec%0d_be", i), 32'(mem_be_o), 32'(vt[i].e_be));
            chk($sformatf("vec%0d_iv", i), 32'(inst_valid_o), 32'(vt[i].e_iv));
            chk($sformatf("vec%0d_da", i), 32'(data_access_o), 32'(vt[i].e_da));
            chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vt[i].e_busy));
        end

        // ---- wrap-around of the sequential PC ----
        idle_inputs();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_top_addr", mem_addr_o, 32'hFFFF_FFFC);
        idle_inputs();
        step();
        chk("wrap_zero_addr", mem_addr_o, 32'h0);
        chk("wrap_zero_pc", pc_o, 32'h0);

        // ---- reset in the middle of a stalled store ----
        mem_op_i = 2'b10; mem_addr_i = 32'h400; mem_wdata_i = 32'hA5A5_A5A5; mem_be_i = 4'hF;
        step();
        chk("st_issue_we", 32'(mem_we_o), 32'd1);
        chk("st_issue_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        idle_inputs();
        mem_ready_i = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst_ce", 32'(mem_ce_o), 32'd0);
        chk("midrst_we", 32'(mem_we_o), 32'd0);
        chk("midrst_da", 32'(data_access_o), 32'd0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        rst = 1'b1;
        mem_ready_i = 1'b1;
        step();
        chk("midrst_refetch_ce", 32'(mem_ce_o), 32'd1);
        chk("midrst_refetch_iv", 32'(inst_valid_o), 32'd1);
        chk("midrst_refetch_addr", mem_addr_o, 32'h0);

        // ---- misaligned branch target ----
        branch_flag_i = 1'b1; branch_target_i = 32'h42;
        step();
`ifdef PC_MISALIGN_EN
        chk("mis_ce", 32'(mem_ce_o), 32'd0);
        chk("mis_pc", pc_o, 32'h42);
        chk("mis_excp", 32'(excp_misalign_o), 32'd1);
        idle_inputs();
        mem_op_i = 2'b01; mem_addr_i = 32'h500; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        step();
        chk("mis_hold_ce", 32'(mem_ce_o), 32'd0);
        chk("mis_hold_excp", 32'(excp_misalign_o), 32'd0);
        chk("mis_hold_da", 32'(data_access_o), 32'd0);
        idle_inputs();
        flush = 1'b1; new_pc = 32'h100;
        step();
        chk("mis_exit_ce", 32'(mem_ce_o), 32'd1);
        chk("mis_exit_addr", mem_addr_o, 32'h100);
`else
        chk("align_addr", mem_addr_o, 32'h40);
        chk("align_pc", pc_o, 32'h40);
`endif
        idle_inputs();

        // ---- randomized traffic vs. model ----
        rst = 1'b0;
        @(posedge clk);
        m_step();
        #1;
        rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 299) != 0);
            flush           = ($urandom_range(0, 19) == 0);
            new_pc          = $urandom();
            stall_i         = ($urandom_range(0, 4) == 0);
            branch_flag_i   = ($urandom_range(0, 6) == 0);
            branch_target_i = $urandom();
            mem_op_i        = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) mem_op_i = 2'b00;
            mem_addr_i      = $urandom();
            mem_wdata_i     = $urandom();
            mem_be_i        = 4'($urandom());
            mem_ready_i     = ($urandom_range(0, 9) < 7);
`ifdef PC_MISALIGN_EN
            if ($urandom_range(0, 7) != 0) begin
                new_pc          = new_pc & ~32'(IB - 1);
                branch_target_i = branch_target_i & ~32'(IB - 1);
            end
`endif
            @(posedge clk);
            m_step();
            #1;
            chk("rnd_ce", 32'(mem_ce_o), 32'(m_ce));
            chk("rnd_we", 32'(mem_we_o), 32'(m_we));
            chk("rnd_pc", pc_o, m_pc);
            chk("rnd_iv", 32'(inst_valid_o), 32'(m_iv));
            chk("rnd_da", 32'(data_access_o), 32'(m_da));
            chk("rnd_busy", 32'(busy_o), 32'(m_ce & ~mem_ready_i));
            if (m_ce) begin
                chk("rnd_addr", mem_addr_o, m_addr);
                chk("rnd_be", 32'(mem_be_o), 32'(m_be));
            end
            if (m_ce && m_we) chk("rnd_wdata", mem_wdata_o, m_wdata);
`ifdef PC_MISALIGN_EN
            chk("rnd_excp", 32'(excp_misalign_o), 32'(m_exc));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
